// File: rtl/alu_div_pkg.sv
// Shared types for the sequential divider: FSM state and counter sizing.
// Optional zero-divisor shortcut is enabled with DIV_ZERO_DETECT_EN.
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring divide iteration: shift {A,Q} left, trial-subtract divisor.
// Purely combinational; the top level registers the results.
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH+1:0] sa;
    logic [WIDTH+1:0] t;

    assign sa = {a, q[WIDTH-1]};
    assign t  = sa - {2'b00, d};

    // A stays below the divisor, so a borrow out of the top bit means restore
    always_comb begin
        q_nxt = {q[WIDTH-2:0], 1'b0};
        a_nxt = sa[WIDTH:0];
        if (!t[WIDTH+1]) begin
            a_nxt    = t[WIDTH:0];
            q_nxt[0] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_div.sv
// Multi-cycle restoring divider, signed/unsigned, start/busy/done handshake.
// Define DIV_ZERO_DETECT_EN to short-circuit zero divisors with a flag.
module alu_seq_div
    import alu_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] dv;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    assign dd_neg = signed_op & dividend[WIDTH-1];
    assign dv_neg = signed_op & divisor[WIDTH-1];
    assign dd_mag = dd_neg ? -dividend : dividend;
    assign dv_mag = dv_neg ? -divisor : divisor;

`ifdef DIV_ZERO_DETECT_EN
    logic [WIDTH-1:0] raw;
    logic             dz;
`else
    assign div_zero = 1'b0;
`endif

    alu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a    (a),
        .q    (q),
        .d    (dv),
        .a_nxt(a_nxt),
        .q_nxt(q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            a         <= '0;
            q         <= '0;
            dv        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            raw       <= '0;
            dz        <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        q     <= dd_mag;
                        dv    <= dv_mag;
                        neg_q <= dd_neg ^ dv_neg;
                        neg_r <= dd_neg;
                        count <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                        raw   <= dividend;
                        dz    <= (divisor == '0);
                        state <= (divisor == '0) ? FIX : RUN;
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    a <= a_nxt;
                    q <= q_nxt;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= raw;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= neg_q ? -q : q;
                        remainder <= neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
                        div_zero  <= 1'b0;
                    end
`else
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_div.sv
// Randomised and directed bench for alu_seq_div against an arithmetic model.
// Honours DIV_ZERO_DETECT_EN the same way as the design build.
module tb_alu_seq_div;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 0, sop32 = 0;
    logic [31:0] dd32 = 0, dv32 = 0;
    logic        busy32, done32, dz32;
    logic [31:0] q32, r32;

    logic        start8 = 0, sop8 = 0;
    logic [7:0]  dd8 = 0, dv8 = 0;
    logic        busy8, done8, dz8;
    logic [7:0]  q8, r8;

    int n_chk = 0;
    int n_fail = 0;

    alu_seq_div #(.WIDTH(32)) u32 (
        .clk(clk), .clr_n(clr_n), .start(start32), .signed_op(sop32),
        .dividend(dd32), .divisor(dv32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_zero(dz32)
    );

    alu_seq_div #(.WIDTH(8)) u8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .signed_op(sop8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_zero(dz8)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit zdet();
`ifdef DIV_ZERO_DETECT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Truncating division on sign-extended 64-bit values, masked to w bits
    function automatic void model(input int w, input bit s, input longint a,
                                  input longint b, output longint q,
                                  output longint r, output longint dz,
                                  output int lat);
        longint mask = (longint'(1) <<< w) - 1;
        longint sa = a;
        longint sb = b;
        lat = w + 2;
        dz  = 0;
        if (b == 0) begin
            q = mask;
            r = a;
            if (zdet()) begin
                dz  = 1;
                lat = 2;
            end
            return;
        end
        if (s && a[w-1]) sa = a - (longint'(1) <<< w);
        if (s && b[w-1]) sb = b - (longint'(1) <<< w);
        q = (sa / sb) & mask;
        r = (sa % sb) & mask;
    endfunction

    task automatic launch(input bit w8, input bit s, input logic [31:0] a,
                          input logic [31:0] b);
        if (w8) begin
            start8 = 1; sop8 = s; dd8 = a[7:0]; dv8 = b[7:0];
        end else begin
            start32 = 1; sop32 = s; dd32 = a; dv32 = b;
        end
        @(posedge clk);
        @(negedge clk);
        start8 = 0;
        start32 = 0;
    endtask

    // Returns at the negedge of the done cycle; poke re-pulses start while busy
    task automatic wait_done(input bit w8, input int lat, input int poke,
                             input string tag);
        int cyc = 1;
        int bhigh = 0;
        while (!(w8 ? done8 : done32) && cyc < 200) begin
            if (w8 ? busy8 : busy32) bhigh++;
            if (poke != 0 && cyc == poke) begin
                start32 = 1; sop32 = 1; dd32 = 32'h1234_5678; dv32 = 32'd5;
            end
            if (cyc == poke + 1) start32 = 0;
            @(negedge clk);
            cyc++;
        end
        start32 = 0;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy@done"}, longint'(w8 ? busy8 : busy32), 0);
        chk({tag, " busy cycles"}, bhigh, lat - 1);
    endtask

    task automatic check_res(input bit w8, input bit s, input logic [31:0] a,
                             input logic [31:0] b, input string tag);
        longint eq, er, ez;
        int lat;
        model(w8 ? 8 : 32, s, longint'(a), longint'(b), eq, er, ez, lat);
        chk({tag, " quotient"}, w8 ? longint'(q8) : longint'(q32), eq);
        chk({tag, " remainder"}, w8 ? longint'(r8) : longint'(r32), er);
        chk({tag, " div_zero"}, w8 ? longint'(dz8) : longint'(dz32), ez);
    endtask

    task automatic do_op(input bit w8, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input int poke, input string tag);
        longint eq, er, ez;
        int lat;
        model(w8 ? 8 : 32, s, longint'(w8 ? {24'd0, a[7:0]} : a),
              longint'(w8 ? {24'd0, b[7:0]} : b), eq, er, ez, lat);
        launch(w8, s, a, b);
        wait_done(w8, lat, poke, tag);
        check_res(w8, s, w8 ? {24'd0, a[7:0]} : a,
                  w8 ? {24'd0, b[7:0]} : b, tag);
        @(negedge clk);
        chk({tag, " done pulse"}, longint'(w8 ? done8 : done32), 0);
        chk({tag, " hold"}, w8 ? longint'(q8) : longint'(q32), eq);
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb;
        bit rs;

        repeat (3) @(negedge clk);
        chk("rst busy", busy32, 0);
        chk("rst done", done32, 0);
        chk("rst quotient", q32, 0);
        chk("rst remainder", r32, 0);
        chk("rst div_zero", dz32, 0);
        clr_n = 1;
        @(negedge clk);

        do_op(0, 0, 32'd100, 32'd7, 0, "u 100/7");
        do_op(0, 1, 32'(-100), 32'd7, 0, "s -100/7");
        do_op(0, 1, 32'd100, 32'(-7), 0, "s 100/-7");
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s ovf");
        do_op(0, 0, 32'hFFFF_FFFF, 32'd1, 0, "u max/1");
        do_op(0, 0, 32'd55, 32'd0, 0, "u 55/0");
        do_op(0, 0, 32'd100, 32'd7, 5, "busy poke");

        launch(0, 0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        clr_n = 0;
        @(negedge clk);
        chk("midrst busy", busy32, 0);
        chk("midrst done", done32, 0);
        chk("midrst quotient", q32, 0);
        chk("midrst remainder", r32, 0);
        chk("midrst div_zero", dz32, 0);
        clr_n = 1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) dones++;
        end
        chk("midrst no done", dones, 0);
        do_op(0, 0, 32'd9, 32'd3, 0, "post-rst 9/3");

        launch(1, 0, 32'd50, 32'd7);
        wait_done(1, 10, 0, "b2b first");
        check_res(1, 0, 32'd50, 32'd7, "b2b first");
        launch(1, 0, 32'd200, 32'd13);
        wait_done(1, 10, 0, "b2b second");
        check_res(1, 0, 32'd200, 32'd13, "b2b second");

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (rs && $urandom_range(0, 3) == 0) rb = -rb;
            if (rb == 0) rb = 32'd1;
            do_op(0, rs, ra, rb, 0, "rand32");
        end
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (rb[7:0] == 8'd0) rb = 32'd3;
            do_op(1, rs, ra, rb, 0, "rand8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
